clk_rst_sequencer: RTL and testbench

Reset and start-up sequencer directly downstream of the board clock generator (MMCM: 100 MHz in; 100 MHz, 100 MHz @45°, 200 MHz, 200 MHz @180° and 200 MHz @135° out, plus `locked`). It synchronises the generator's asynchronous `locked` output into the 100 MHz domain and qualifies it for stability. It then releases the PHY, controller and core resets in a fixed order, handshakes a memory-init/calibration step, and tears everything down on loss of lock. Per-domain reset synchronisers in the fast clock domains consume its outputs.

---
 rtl/clk_rst_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_clk_rst_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_sequencer.sv
// Start-up sequencer: synchronises and qualifies MMCM lock, releases PHY/controller/core
// resets in order, handshakes calibration, and tears everything down on lock loss.
`timescale 1ns/1ps
module clk_rst_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int INIT_TIMEOUT       = 65536
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       locked_i,
    input  logic       init_done_i,
    output logic       rst_phy_o,
    output logic       rst_ctrl_o,
    output logic       rst_core_o,
    output logic       init_start_o,
    output logic       ready_o,
    output logic       init_fail_o,
    output logic [7:0] lock_loss_cnt_o,
    output logic [2:0] state_o
);

    localparam int MAX_AB = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
    localparam int MAX_C  = (MAX_AB > INIT_TIMEOUT) ? MAX_AB : INIT_TIMEOUT;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(INIT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        REL_PHY   = 3'd2,
        REL_CTRL  = 3'd3,
        INIT      = 3'd4,
        READY     = 3'd5,
        FAIL      = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rst_phy_q, rst_phy_d;
    logic          rst_ctrl_q, rst_ctrl_d;
    logic          rst_core_q, rst_core_d;
    logic          init_start_q, init_start_d;
    logic          ready_q, ready_d;
    logic          init_fail_q, init_fail_d;
    logic [7:0]    loss_cnt_q, loss_cnt_d;

    // locked_i enters at bit 0; the last stage is the qualified-domain view.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            rst_phy_q    <= 1'b1;
            rst_ctrl_q   <= 1'b1;
            rst_core_q   <= 1'b1;
            init_start_q <= 1'b0;
            ready_q      <= 1'b0;
            init_fail_q  <= 1'b0;
            loss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rst_phy_q    <= rst_phy_d;
            rst_ctrl_q   <= rst_ctrl_d;
            rst_core_q   <= rst_core_d;
            init_start_q <= init_start_d;
            ready_q      <= ready_d;
            init_fail_q  <= init_fail_d;
            loss_cnt_q   <= loss_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rst_phy_d    = rst_phy_q;
        rst_ctrl_d   = rst_ctrl_q;
        rst_core_d   = rst_core_q;
        init_start_d = 1'b0;
        ready_d      = ready_q;
        init_fail_d  = init_fail_q;
        loss_cnt_d   = loss_cnt_q;

        // Lock loss anywhere from STABLE to READY takes precedence over progress.
        if (!locked_s && state_q != WAIT_LOCK && state_q != FAIL) begin
            state_d    = WAIT_LOCK;
            cnt_d      = '0;
            rst_phy_d  = 1'b1;
            rst_ctrl_d = 1'b1;
            rst_core_d = 1'b1;
            ready_d    = 1'b0;
            if (state_q == READY && loss_cnt_q != 8'hFF) begin
                loss_cnt_d = loss_cnt_q + 8'd1;
            end
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_d      = '0;
                    rst_phy_d  = 1'b1;
                    rst_ctrl_d = 1'b1;
                    rst_core_d = 1'b1;
                    ready_d    = 1'b0;
                    if (locked_s) begin
                        state_d = STABLE;
                    end
                end
                STABLE: begin
                    if (cnt_q == STABLE_LAST) begin
                        state_d   = REL_PHY;
                        cnt_d     = '0;
                        rst_phy_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REL_PHY: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d    = REL_CTRL;
                        cnt_d      = '0;
                        rst_ctrl_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REL_CTRL: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d      = INIT;
                        cnt_d        = '0;
                        init_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                INIT: begin
                    if (init_done_i) begin
                        state_d    = READY;
                        cnt_d      = '0;
                        rst_core_d = 1'b0;
                        ready_d    = 1'b1;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = FAIL;
                        cnt_d       = '0;
                        rst_phy_d   = 1'b1;
                        rst_ctrl_d  = 1'b1;
                        rst_core_d  = 1'b1;
                        ready_d     = 1'b0;
                        init_fail_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                READY: begin
                    cnt_d = '0;
                end
                FAIL: begin
                    rst_phy_d   = 1'b1;
                    rst_ctrl_d  = 1'b1;
                    rst_core_d  = 1'b1;
                    ready_d     = 1'b0;
                    init_fail_d = 1'b1;
                end
                default: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign rst_phy_o       = rst_phy_q;
    assign rst_ctrl_o      = rst_ctrl_q;
    assign rst_core_o      = rst_core_q;
    assign init_start_o    = init_start_q;
    assign ready_o         = ready_q;
    assign init_fail_o     = init_fail_q;
    assign lock_loss_cnt_o = loss_cnt_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Scoreboard bench for clk_rst_sequencer: stimulus queues edge-stamped output snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_clk_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       locked_i;
    logic       init_done_i;
    logic       rst_phy_o, rst_ctrl_o, rst_core_o;
    logic       init_start_o, ready_o, init_fail_o;
    logic [7:0] lock_loss_cnt_o;
    logic [2:0] state_o;

    clk_rst_sequencer #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(8),
        .STAGE_GAP_CYCLES  (4),
        .INIT_TIMEOUT      (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .locked_i       (locked_i),
        .init_done_i    (init_done_i),
        .rst_phy_o      (rst_phy_o),
        .rst_ctrl_o     (rst_ctrl_o),
        .rst_core_o     (rst_core_o),
        .init_start_o   (init_start_o),
        .ready_o        (ready_o),
        .init_fail_o    (init_fail_o),
        .lock_loss_cnt_o(lock_loss_cnt_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far; "edge k" is the k-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at_edge;
        string       nm;
        logic [16:0] v;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Snapshot layout: {state, phy, ctrl, core, start, ready, fail, loss_cnt}
    task automatic push(input int e, input string nm, input logic [2:0] st,
                        input logic phy, input logic ctrl, input logic core,
                        input logic start, input logic rdy, input logic fl,
                        input logic [7:0] cnt);
        exp_t x;
        x.at_edge = e;
        x.nm      = nm;
        x.v       = {st, phy, ctrl, core, start, rdy, fl, cnt};
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        logic [16:0] act;
        act = {state_o, rst_phy_o, rst_ctrl_o, rst_core_o, init_start_o, ready_o,
               init_fail_o, lock_loss_cnt_o};
        while (q.size() > 0 && q[0].at_edge <= cyc) begin
            exp_t x;
            x = q.pop_front();
            n_tests++;
            if (x.at_edge < cyc) begin
                n_fail++;
                $display("FAIL %s: check for edge %0d missed at edge %0d", x.nm, x.at_edge, cyc);
            end else if (act !== x.v) begin
                n_fail++;
                $display("FAIL %s @edge %0d: got st=%0d phy/ctrl/core=%b%b%b start=%b rdy=%b fail=%b cnt=%0d, want %h (st=%0d rsts=%b start=%b rdy=%b fail=%b cnt=%0d)",
                         x.nm, cyc, state_o, rst_phy_o, rst_ctrl_o, rst_core_o, init_start_o,
                         ready_o, init_fail_o, lock_loss_cnt_o, x.v, x.v[16:14], x.v[13:11],
                         x.v[10], x.v[9], x.v[8], x.v[7:0]);
            end else begin
                $display("[TB] edge %0d %s ok st=%0d cnt=%0d", cyc, x.nm, state_o, lock_loss_cnt_o);
            end
        end
    end

    task automatic goto_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic do_reset();
        int c;
        c = cyc;
        rst_i       = 1'b1;
        locked_i    = 1'b0;
        init_done_i = 1'b0;
        push(c + 1, "reset", 3'd0, 1, 1, 1, 0, 0, 0, 8'd0);
        goto_edge(c + 1);
    endtask

    // Raise lock for edge 0 = next edge; init_done sampled high at done_n (<0: never).
    task automatic bringup(input int done_n, input int stop_n, input logic [7:0] cnt,
                           output int e0);
        int c;
        c  = cyc;
        e0 = c + 1;
        rst_i    = 1'b0;
        locked_i = 1'b1;
        if (stop_n >= 0)  push(e0 + 0,  "wait_lock", 3'd0, 1, 1, 1, 0, 0, 0, cnt);
        if (stop_n >= 2)  push(e0 + 2,  "stable",    3'd1, 1, 1, 1, 0, 0, 0, cnt);
        if (stop_n >= 9)  push(e0 + 9,  "phy_held",  3'd1, 1, 1, 1, 0, 0, 0, cnt);
        if (stop_n >= 10) push(e0 + 10, "phy_rel",   3'd2, 0, 1, 1, 0, 0, 0, cnt);
        if (stop_n >= 13) push(e0 + 13, "ctrl_held", 3'd2, 0, 1, 1, 0, 0, 0, cnt);
        if (stop_n >= 14) push(e0 + 14, "ctrl_rel",  3'd3, 0, 0, 1, 0, 0, 0, cnt);
        if (stop_n >= 17) push(e0 + 17, "pre_start", 3'd3, 0, 0, 1, 0, 0, 0, cnt);
        if (stop_n >= 18) push(e0 + 18, "start",     3'd4, 0, 0, 1, 1, 0, 0, cnt);
        if (stop_n >= 19 && (done_n < 0 || done_n > 19))
            push(e0 + 19, "start_off", 3'd4, 0, 0, 1, 0, 0, 0, cnt);
        if (done_n > 20 && stop_n >= done_n)
            push(e0 + done_n - 1, "init_wait", 3'd4, 0, 0, 1, 0, 0, 0, cnt);
        if (done_n >= 19 && stop_n >= done_n)
            push(e0 + done_n, "ready", 3'd5, 0, 0, 0, 0, 1, 0, cnt);
        if (done_n >= 19 && stop_n >= done_n) begin
            goto_edge(e0 + done_n - 1);
            init_done_i = 1'b1;
        end
        goto_edge(e0 + stop_n);
    endtask

    task automatic lose_lock(input logic [7:0] cnt_before, input logic [7:0] cnt_after);
        int f;
        f = cyc + 1;
        locked_i    = 1'b0;
        init_done_i = 1'b0;
        push(f + 1, "loss_lag",  3'd5, 0, 0, 0, 0, 1, 0, cnt_before);
        push(f + 2, "loss_down", 3'd0, 1, 1, 1, 0, 0, 0, cnt_after);
        goto_edge(f + 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int c;
        logic [7:0] cb, ca;
        rst_i       = 1'b1;
        locked_i    = 1'b0;
        init_done_i = 1'b0;
        @(negedge clk);

        // Nominal bring-up, then lock loss in READY and a repeated sequence
        do_reset();
        bringup(25, 25, 8'd0, e0);
        lose_lock(8'd0, 8'd1);
        bringup(19, 19, 8'd1, e0);

        // Unstable lock: high 5 edges, low 5 edges, high from edge 10
        do_reset();
        c  = cyc;
        e0 = c + 1;
        rst_i    = 1'b0;
        locked_i = 1'b1;
        push(e0 + 2,  "unst_stable", 3'd1, 1, 1, 1, 0, 0, 0, 8'd0);
        push(e0 + 8,  "unst_lost",   3'd0, 1, 1, 1, 0, 0, 0, 8'd0);
        push(e0 + 19, "unst_held",   3'd1, 1, 1, 1, 0, 0, 0, 8'd0);
        push(e0 + 20, "unst_phy",    3'd2, 0, 1, 1, 0, 0, 0, 8'd0);
        goto_edge(e0 + 4);
        locked_i = 1'b0;
        goto_edge(e0 + 9);
        locked_i = 1'b1;
        goto_edge(e0 + 20);

        // Init timeout into FAIL, lock toggling ignored, rst_i recovers
        do_reset();
        bringup(-1, 19, 8'd0, e0);
        push(e0 + 49, "to_wait", 3'd4, 0, 0, 1, 0, 0, 0, 8'd0);
        push(e0 + 50, "to_fail", 3'd6, 1, 1, 1, 0, 0, 1, 8'd0);
        goto_edge(e0 + 52);
        locked_i = 1'b0;
        goto_edge(e0 + 56);
        locked_i = 1'b1;
        push(e0 + 62, "fail_sticky", 3'd6, 1, 1, 1, 0, 0, 1, 8'd0);
        goto_edge(e0 + 62);
        do_reset();

        // Lock loss and init_done in the same cycle: loss wins
        bringup(-1, 18, 8'd0, e0);
        goto_edge(e0 + 19);
        locked_i = 1'b0;
        push(e0 + 21, "sim_lag",  3'd4, 0, 0, 1, 0, 0, 0, 8'd0);
        push(e0 + 22, "sim_loss", 3'd0, 1, 1, 1, 0, 0, 0, 8'd0);
        goto_edge(e0 + 21);
        init_done_i = 1'b1;
        goto_edge(e0 + 22);
        init_done_i = 1'b0;

        // rst_i pulsed in REL_CTRL, then a full restart
        do_reset();
        bringup(-1, 15, 8'd0, e0);
        c = cyc;
        rst_i = 1'b1;
        push(c + 1, "rst_in_ctrl", 3'd0, 1, 1, 1, 0, 0, 0, 8'd0);
        goto_edge(c + 1);
        bringup(19, 19, 8'd0, e0);

        // 300 losses from READY saturate the counter at 255
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cb = (i < 255) ? 8'(i) : 8'd255;
            ca = (i < 254) ? 8'(i + 1) : 8'd255;
            bringup(19, 19, cb, e0);
            lose_lock(cb, ca);
        end
        c = cyc;
        push(c + 1, "sat_final", 3'd0, 1, 1, 1, 0, 0, 0, 8'd255);
        goto_edge(c + 3);

        if (q.size() != 0) begin
            n_tests += q.size();
            n_fail  += q.size();
            $display("FAIL leftover: %0d checks pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
